// File: rtl/tnn_pkg.sv
// Shared types and helpers for the ternary-NN neuron family.
package tnn_pkg;

   typedef enum logic {
      ST_ACC  = 1'b0,
      ST_HOLD = 1'b1
   } tnn_state_e;

   function automatic int acc_width(input int in_w, input int max_terms);
      return in_w + $clog2(max_terms + 1);
   endfunction

   // Signed threshold decision; tie_one selects >= instead of >.
   function automatic logic thresh_cmp(input logic signed [31:0] diff,
                                       input logic signed [31:0] thresh,
                                       input logic               tie_one);
      return tie_one ? (diff >= thresh) : (diff > thresh);
   endfunction

endpackage

// File: rtl/tnn_dual_acc.sv
// Positive/negative term accumulators with a saturating beat counter and
// overflow flag. The *_nxt_o outputs show the sums including the current beat.
module tnn_dual_acc
   import tnn_pkg::*;
#(
   parameter int IN_W      = 3,
   parameter int MAX_TERMS = 16,
   parameter int ACC_W     = acc_width(IN_W, MAX_TERMS)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             clear_i,
   input  logic             add_i,
   input  logic [IN_W-1:0]  data_i,
   input  logic             neg_i,
   output logic [ACC_W-1:0] pos_nxt_o,
   output logic [ACC_W-1:0] neg_nxt_o,
   output logic             ovf_nxt_o
);

   localparam int CNT_W = $clog2(MAX_TERMS + 1);

   logic [ACC_W-1:0] pos_q, pos_d;
   logic [ACC_W-1:0] neg_q, neg_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             ovf_q, ovf_d;
   logic             full;

   always_comb begin
      pos_d = pos_q;
      neg_d = neg_q;
      cnt_d = cnt_q;
      ovf_d = ovf_q;
      full  = (cnt_q == CNT_W'(MAX_TERMS));
      // A beat beyond MAX_TERMS is dropped and only marks the frame overflowed.
      if (add_i) begin
         if (full) begin
            ovf_d = 1'b1;
         end else begin
            cnt_d = cnt_q + CNT_W'(1);
            if (neg_i) neg_d = neg_q + ACC_W'(data_i);
            else       pos_d = pos_q + ACC_W'(data_i);
         end
      end
   end

   assign pos_nxt_o = pos_d;
   assign neg_nxt_o = neg_d;
   assign ovf_nxt_o = ovf_d;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pos_q <= '0;
         neg_q <= '0;
         cnt_q <= '0;
         ovf_q <= 1'b0;
      end else if (clear_i) begin
         pos_q <= '0;
         neg_q <= '0;
         cnt_q <= '0;
         ovf_q <= 1'b0;
      end else begin
         pos_q <= pos_d;
         neg_q <= neg_d;
         cnt_q <= cnt_d;
         ovf_q <= ovf_d;
      end
   end

endmodule

// File: rtl/tnn_neuron_stream.sv
// Streaming ternary neuron: accumulates a tagged frame of activations and
// emits one thresholded decision per frame over a valid/ready handshake.
module tnn_neuron_stream
   import tnn_pkg::*;
#(
   parameter int  IN_W      = 3,
   parameter int  MAX_TERMS = 16,
   parameter int  THRESH    = 0,
   parameter int  TIE_ONE   = 0,
   localparam int ACC_W     = acc_width(IN_W, MAX_TERMS)
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [IN_W-1:0] in_data,
   input  logic            in_neg,
   input  logic            in_last,
   output logic            out_valid,
   input  logic            out_ready,
   output logic            out_bit,
   output logic [ACC_W:0]  out_diff,
   output logic            out_ovf
);

   localparam logic signed [ACC_W:0] THR_EXT = (ACC_W+1)'(THRESH);

   tnn_state_e state_q, state_d;
   logic              out_bit_q, out_bit_d;
   logic [ACC_W:0]    out_diff_q, out_diff_d;
   logic              out_ovf_q, out_ovf_d;
   logic              beat, load, dec;
   logic [ACC_W-1:0]  pos_nxt, neg_nxt;
   logic              ovf_nxt;
   logic signed [ACC_W:0] diff_w;

   assign in_ready  = (state_q == ST_ACC) | out_ready;
   assign out_valid = (state_q == ST_HOLD);
   assign beat      = in_valid & in_ready;

   tnn_dual_acc #(
      .IN_W      (IN_W),
      .MAX_TERMS (MAX_TERMS),
      .ACC_W     (ACC_W)
   ) u_acc (
      .clk       (clk),
      .rst_n     (rst_n),
      .clear_i   (beat & in_last),
      .add_i     (beat),
      .data_i    (in_data),
      .neg_i     (in_neg),
      .pos_nxt_o (pos_nxt),
      .neg_nxt_o (neg_nxt),
      .ovf_nxt_o (ovf_nxt)
   );

   assign diff_w = $signed({1'b0, pos_nxt}) - $signed({1'b0, neg_nxt});
   assign dec    = thresh_cmp({{(31-ACC_W){diff_w[ACC_W]}}, diff_w},
                              {{(31-ACC_W){THR_EXT[ACC_W]}}, THR_EXT},
                              TIE_ONE != 0);

   always_comb begin
      state_d    = state_q;
      out_bit_d  = out_bit_q;
      out_diff_d = out_diff_q;
      out_ovf_d  = out_ovf_q;
      load       = 1'b0;
      unique case (state_q)
         ST_ACC: begin
            if (beat && in_last) begin
               load    = 1'b1;
               state_d = ST_HOLD;
            end
         end
         ST_HOLD: begin
            // Retiring cycle also accepts a beat; a single-beat frame reloads.
            if (out_ready) begin
               if (beat && in_last) load    = 1'b1;
               else                 state_d = ST_ACC;
            end
         end
         default: state_d = ST_ACC;
      endcase
      if (load) begin
         out_bit_d  = dec & ~ovf_nxt;
         out_diff_d = diff_w;
         out_ovf_d  = ovf_nxt;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= ST_ACC;
         out_bit_q  <= 1'b0;
         out_diff_q <= '0;
         out_ovf_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         out_bit_q  <= out_bit_d;
         out_diff_q <= out_diff_d;
         out_ovf_q  <= out_ovf_d;
      end
   end

   assign out_bit  = out_bit_q;
   assign out_diff = out_diff_q;
   assign out_ovf  = out_ovf_q;

endmodule
